// File: rtl/dct2_burst_sequencer_pkg.sv
// Shared defaults and the read-side state encoding for the DCT-II burst sequencer.
package dct2_burst_sequencer_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_COEF   = 13;
  localparam int DEF_GAP_CYCLES = 2;

  // Read FSM: wait for a full bank, replay it, then hold the guard gap.
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BURST = 2'd1,
    RD_GAP   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dct2_pingpong_buf.sv
// Two frame-sized register banks with one write port, one read port and
// per-bank full flags that the write side sets and the read side clears.
module dct2_pingpong_buf #(
  parameter int DATA_W   = 32,
  parameter int NUM_COEF = 13,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_en,
  input  logic              set_bank,
  input  logic              clr_en,
  input  logic              clr_bank,
  input  logic              rd_bank,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        full
);

  logic [DATA_W-1:0] mem_q [2][NUM_COEF];
  logic [DATA_W-1:0] mem_d [2][NUM_COEF];
  logic [1:0]        full_q;
  logic [1:0]        full_d;

  // Next-state for the banks and their occupancy flags.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    mem_d  = mem_q;
    full_d = full_q;
    if (wr_en) mem_d[wr_bank][wr_idx] = wr_data;
    // The write side only ever fills an empty bank and the read side only
    // drains a full one, so set and clear never target the same bank.
    if (set_en) full_d[set_bank] = 1'b1;
    if (clr_en) full_d[clr_bank] = 1'b0;
  end

  // Full flags are reset; sample storage is not.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) full_q <= 2'b00;
    else     full_q <= full_d;
  end

  // Sample storage register update.
  always_ff @(posedge clk) begin
    // NOTE: the banks carry no reset; their contents are only observed once a full flag (which is reset) marks them valid.
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_bank][rd_idx];
  assign full    = full_q;

endmodule

// File: rtl/dct2_burst_sequencer.sv
// Collects gappy input frames into a ping-pong buffer and replays each
// complete frame as one contiguous NUM_COEF-cycle burst plus a guard gap.
module dct2_burst_sequencer
  import dct2_burst_sequencer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_COEF   = DEF_NUM_COEF,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [15:0]       frame_cnt,
  output logic              frame_err
);

  localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  // Write side state.
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             drop_q, drop_d;
  logic             frame_err_q, frame_err_d;
  logic             wr_en, set_en, accept;

  // Read side state.
  rd_state_e         state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic              clr_en, emit;

  logic [DATA_W-1:0] rd_data;
  logic [1:0]        full;

  dct2_pingpong_buf #(
    .DATA_W   (DATA_W),
    .NUM_COEF (NUM_COEF),
    .IDX_W    (IDX_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank_q),
    .wr_idx   (wr_idx_q),
    .wr_data  (s_tdata),
    .set_en   (set_en),
    .set_bank (wr_bank_q),
    .clr_en   (clr_en),
    .clr_bank (rd_bank_q),
    .rd_bank  (rd_bank_q),
    .rd_idx   (rd_idx_q),
    .rd_data  (rd_data),
    .full     (full)
  );

  // Back-pressure only when the bank we would write into is still occupied.
  assign s_tready = ~full[wr_bank_q];
  assign accept   = s_tvalid & s_tready;

  // Frame assembly: index beats, commit well-formed frames, flag and drop malformed ones.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    drop_d      = drop_q;
    frame_err_d = frame_err_q;
    wr_en       = 1'b0;
    set_en      = 1'b0;
    if (accept) begin
      if (drop_q) begin
        // Discarding the tail of an over-long frame up to its tlast.
        if (s_tlast) drop_d = 1'b0;
      end else begin
        wr_en = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          wr_idx_d = '0;
          if (s_tlast) begin
            set_en    = 1'b1;
            wr_bank_d = ~wr_bank_q;
          end else begin
            frame_err_d = 1'b1;
            drop_d      = 1'b1;
          end
        end else if (s_tlast) begin
          frame_err_d = 1'b1;
          wr_idx_d    = '0;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
    end
  end

  // Read FSM: registered outputs, so a sample is issued the cycle before it appears.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    m_tvalid_d  = 1'b0;
    m_tdata_d   = '0;
    m_tlast_d   = 1'b0;
    clr_en      = 1'b0;
    // Idle issues index 0 directly so the burst starts one cycle after the frame lands.
    emit = (state_q == RD_BURST) || ((state_q == RD_IDLE) && full[rd_bank_q]);
    if (emit) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = rd_data;
      if (rd_idx_q == LAST_IDX) begin
        m_tlast_d   = 1'b1;
        clr_en      = 1'b1;
        rd_bank_d   = ~rd_bank_q;
        rd_idx_d    = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        gap_cnt_d   = '0;
        state_d     = RD_GAP;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
        state_d  = RD_BURST;
      end
    end else if (state_q == RD_GAP) begin
      // Leaving after the last guard cycle lets idle start the next burst with no extra bubble.
      gap_cnt_d = gap_cnt_q + 1'b1;
      if (gap_cnt_q == LAST_GAP) state_d = RD_IDLE;
    end
  end

  // Register update for write side, read FSM and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      drop_q      <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= 16'd0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      drop_q      <= drop_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tlast   = m_tlast_q;
  assign frame_cnt = frame_cnt_q;
  assign frame_err = frame_err_err_alias();

  function automatic logic frame_err_err_alias();
    return frame_err_q;
  endfunction

endmodule

// File: tb/tb_dct2_burst_sequencer.sv
// Randomized bench for dct2_burst_sequencer against a queue-based frame model.
module tb_dct2_burst_sequencer;
  import dct2_burst_sequencer_pkg::*;

  localparam int N   = DEF_NUM_COEF;
  localparam int GAP = DEF_GAP_CYCLES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready, m_tvalid, m_tlast, frame_err;
  logic [31:0] m_tdata;
  logic [15:0] frame_cnt;

  dct2_burst_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .frame_cnt (frame_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // done_q holds complete frames (N words each) not yet fully replayed;
  // each such frame occupies one bank, so at most two can be held.
  logic [31:0] done_q[$];
  logic [31:0] cur_q[$];
  bit          in_burst, dropping, m_err, acc_m;
  int          pos, lows;
  logic [15:0] m_cnt;
  logic        exp_v, exp_l;
  logic [31:0] exp_d;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      done_q.delete();
      cur_q.delete();
      in_burst = 0; dropping = 0; m_err = 0;
      pos = 0; lows = GAP; m_cnt = 16'd0;
      exp_v = 0; exp_d = '0; exp_l = 0;
    end else begin
      acc_m = s_tvalid && (done_q.size() < 2 * N);
      exp_v = 0; exp_d = '0; exp_l = 0;
      if (in_burst) begin
        exp_v = 1; exp_d = done_q[pos]; pos++;
      end else if (done_q.size() >= N && lows >= GAP) begin
        in_burst = 1; exp_v = 1; exp_d = done_q[0]; pos = 1;
      end else if (lows < GAP) begin
        lows++;
      end
      if (in_burst && pos == N) begin
        exp_l = 1; in_burst = 0; lows = 0; m_cnt++;
        repeat (N) void'(done_q.pop_front());
      end
      if (acc_m) begin
        if (dropping) begin
          if (s_tlast) dropping = 0;
        end else begin
          cur_q.push_back(s_tdata);
          if (cur_q.size() == N) begin
            if (s_tlast) foreach (cur_q[i]) done_q.push_back(cur_q[i]);
            else begin m_err = 1; dropping = 1; end
            cur_q.delete();
          end else if (s_tlast) begin
            m_err = 1; cur_q.delete();
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison plus burst-gap and back-pressure observation.
  int  lowrun = 0;
  bit  seen_burst = 0, prev_v = 0, saw_not_ready = 0;
  int  gap_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_tvalid", m_tvalid, exp_v);
      check("m_tdata", m_tdata, exp_d);
      check("m_tlast", m_tlast, exp_l);
      check("frame_cnt", frame_cnt, m_cnt);
      check("frame_err", frame_err, m_err);
      check("s_tready", s_tready, done_q.size() < 2 * N);
      if (!s_tready) saw_not_ready = 1;
      if (m_tvalid) begin
        if (!prev_v && seen_burst) gap_q.push_back(lowrun);
        lowrun = 0; seen_burst = 1;
      end else lowrun++;
      prev_v = m_tvalid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input bit last);
    bit rdy;
    int t = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    do begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 200);
    if (!rdy) check("ready_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit has_last, input int gap_pct, input bit idx_data);
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
      drive_beat(idx_data ? 32'(i) : $urandom, has_last && (i == len - 1));
    end
  endtask

  initial begin
    bit got;
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 32'd0);
    check("rst_m_tdata", m_tdata, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_frame_err", frame_err, 32'd0);
    check("rst_s_tready", s_tready, 32'd1);
    idle(1);

    // 1: back-to-back indexed frame, exact latency and ordering
    send_frame(N, 1, 0, 1);
    @(negedge clk);
    check("t1_latency_low", m_tvalid, 32'd0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("t1_valid", m_tvalid, 32'd1);
      check("t1_data", m_tdata, 32'(k));
      check("t1_last", m_tlast, 32'(k == N - 1));
    end
    @(negedge clk);
    check("t1_after", m_tvalid, 32'd0);
    check("t1_cnt", frame_cnt, 32'd1);
    idle(1);

    // 2: gappy input, contiguous output (checked by model)
    send_frame(N, 1, 40, 0);
    idle(30);
    check("t2_cnt", frame_cnt, 32'd2);

    // 3: three frames at full rate
    do_reset();
    gap_q.delete(); seen_burst = 0; prev_v = 0; saw_not_ready = 0;
    repeat (3) send_frame(N, 1, 0, 0);
    idle(60);
    check("t3_cnt", frame_cnt, 32'd3);
    check("t3_backpressure", saw_not_ready, 32'd1);
    check("t3_ngaps", gap_q.size(), 32'd2);
    foreach (gap_q[i]) check("t3_gap", gap_q[i], GAP);

    // 4: short frame then valid, long frame then valid
    do_reset();
    send_frame(5, 1, 0, 0);
    send_frame(N, 1, 0, 0);
    idle(30);
    check("t4_err", frame_err, 32'd1);
    check("t4_cnt", frame_cnt, 32'd1);
    send_frame(N + 3, 1, 0, 0);
    idle(20);
    check("t4_long_cnt", frame_cnt, 32'd1);
    send_frame(N, 1, 0, 0);
    idle(30);
    check("t4_long_cnt2", frame_cnt, 32'd2);

    // 5: reset on the 6th burst cycle
    do_reset();
    send_frame(N, 1, 0, 0);
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = m_tvalid;
    end
    check("t5_burst_seen", got, 32'd1);
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", m_tvalid, 32'd0);
    check("t5_cnt", frame_cnt, 32'd0);
    check("t5_ready", s_tready, 32'd1);
    idle(1);
    send_frame(N, 1, 0, 0);
    idle(30);
    check("t5_cnt_after", frame_cnt, 32'd1);

    // 6: frame counter wrap
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    idle(1);
    release dut.frame_cnt_q;
    send_frame(N, 1, 0, 0);
    idle(30);
    check("t6_wrap", frame_cnt, 32'd0);

    // 7: random mix of good, short and long frames with random gaps
    do_reset();
    for (int f = 0; f < 25; f++) begin
      int r;
      r = $urandom_range(99);
      if (r < 70)      send_frame(N, 1, $urandom_range(50), 0);
      else if (r < 85) send_frame($urandom_range(1, N - 1), 1, $urandom_range(30), 0);
      else             send_frame(N + $urandom_range(1, 4), 1, $urandom_range(30), 0);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 20));
    end
    idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
